// File: rtl/pmod_adc_capture.sv
// Serial ADC capture front end: drives one shared CS/SCLK frame, shifts in NUM_CH
// MSB-first data lines, averages 2^avg_log2 frames and presents the result on a
// valid/ready port with a sticky overrun flag.
module pmod_adc_capture #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned SAMPLE_BITS   = 16,
    parameter int unsigned DATA_BITS     = 12,
    parameter int unsigned CLKS_PER_BIT  = 20,
    parameter int unsigned CLKS_CS_SETUP = 60,
    parameter int unsigned CLKS_QUIET    = 400
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          continuous,
    input  logic                          start,
    input  logic [2:0]                    avg_log2,
    input  logic                          clear_ovr,
    output logic                          cs_n,
    output logic                          sclk,
    input  logic [NUM_CH-1:0]             sdin,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NUM_CH*DATA_BITS-1:0]   m_data,
    output logic                          overrun,
    output logic                          busy
);

    localparam int unsigned ACC_W = DATA_BITS + 7;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  start_burst, frame_end, sample_en, avg_done;
    logic [2:0]            avg_q;
    logic                  cont_q;
    logic [7:0]            frame_cnt_q;
    // Only the last DATA_BITS shifted bits are the result bits, so the shifter keeps just those.
    logic [DATA_BITS-1:0]  shift_q [NUM_CH];
    logic [ACC_W-1:0]      acc_q   [NUM_CH];
    logic [ACC_W-1:0]      acc_sum [NUM_CH];
    logic [NUM_CH*DATA_BITS-1:0] result;
    logic                  cs_n_q, cs_n_d, sclk_q, sclk_d, busy_q, busy_d;
    logic                  m_valid_q, m_valid_d, overrun_q, overrun_d;
    logic [NUM_CH*DATA_BITS-1:0] m_data_q;
    logic [1:0]            rst_sync_q;
    logic                  rst_n;

    // Reset synchroniser: asserts immediately, releases two clk edges later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Frame sequencer next state; one counter is reused for setup, bit phase and quiet time.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        start_burst = 1'b0;
        frame_end   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && (continuous || start)) begin
                    state_d     = StSetup;
                    cnt_d       = '0;
                    start_burst = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == CNT_W'(CLKS_CS_SETUP - 1)) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StShift: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(SAMPLE_BITS - 1)) begin
                        state_d   = StQuiet;
                        frame_end = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StQuiet: begin
                if (cnt_q == CNT_W'(CLKS_QUIET - 1)) begin
                    cnt_d = '0;
                    // A cleared frame counter means the running average is complete.
                    if (enable && ((cont_q && continuous) || frame_cnt_q != 8'd0)) begin
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin levels are registered from the next state so cs_n/sclk are glitch-free.
    always_comb begin
        cs_n_d    = !(state_d == StSetup || state_d == StShift);
        sclk_d    = !(state_d == StShift && cnt_d < CNT_W'(HALF));
        busy_d    = (state_d != StIdle);
        sample_en = (state_q == StShift) && (cnt_q == CNT_W'(HALF - 1));
    end

    // Sequencer and pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
        end
    end

    // Shift in every data line on the clk edge that raises sclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) shift_q[k] <= '0;
        end else if (sample_en) begin
            for (int k = 0; k < NUM_CH; k++) shift_q[k] <= {shift_q[k][DATA_BITS-2:0], sdin[k]};
        end
    end

    // Running sums and the averaged result for the frame just finished.
    always_comb begin
        avg_done = frame_end && (({1'b0, frame_cnt_q} + 9'd1) == (9'd1 << avg_q));
        result   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_sum[k] = acc_q[k] + ACC_W'(shift_q[k]);
            result[k*DATA_BITS +: DATA_BITS] = DATA_BITS'(acc_sum[k] >> avg_q);
        end
    end

    // Burst settings are latched on IDLE exit; accumulators clear per burst and per result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q       <= '0;
            cont_q      <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
        end else if (start_burst) begin
            avg_q       <= avg_log2;
            cont_q      <= continuous;
            frame_cnt_q <= '0;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
        end else if (frame_end) begin
            if (avg_done) begin
                frame_cnt_q <= '0;
                for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
            end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_sum[k];
            end
        end
    end

    // Output handshake: a new result always loads; overrun only when an unaccepted one is lost.
    always_comb begin
        m_valid_d = m_valid_q;
        overrun_d = overrun_q;
        if (avg_done) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (avg_done && m_valid_q && !m_ready) begin
            overrun_d = 1'b1;
        end else if (clear_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // Output registers; m_data holds after a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            overrun_q <= overrun_d;
            if (avg_done) m_data_q <= result;
        end
    end

    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign overrun = overrun_q;
    assign m_data  = m_data_q;

endmodule

// File: doc/pmod_adc_capture.md
Name: pmod_adc_capture

Overview:
Parametrised successor to the Pmod AD1 capture path. Drives one shared CS/SCLK serial ADC frame and captures NUM_CH parallel MISO lines (AD7476-class, MSB first). Adds single-shot or continuous modes, power-of-two averaging and a valid/ready output with sticky overrun. Sits between the Pmod bridge pins and the AXI register/stream logic.

Parameters:
NUM_CH, 2, number of parallel sdin lines/channels (1..4)
SAMPLE_BITS, 16, SCLK periods per frame
DATA_BITS, 12, valid result bits per channel (LSBs of the frame word, <= SAMPLE_BITS)
CLKS_PER_BIT, 20, clk cycles per SCLK period (even, >= 2)
CLKS_CS_SETUP, 60, clk cycles from cs_n fall to first SCLK low phase
CLKS_QUIET, 400, clk cycles cs_n held high after each frame

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  block enable; low = stop at end of current frame
continuous  in  1  1 = back-to-back results, 0 = single-shot on start
start  in  1  single-cycle pulse; begins one result when idle
avg_log2  in  3  average over 2^avg_log2 frames (0..7)
clear_ovr  in  1  single-cycle pulse clearing overrun
cs_n  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, idles high
sdin  in  NUM_CH  ADC serial data lines
m_valid  out  1  result available
m_ready  in  1  consumer accepts result
m_data  out  NUM_CH*DATA_BITS  channel k at [k*DATA_BITS +: DATA_BITS]
overrun  out  1  sticky: unaccepted result overwritten
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync deassert in clk domain): cs_n=1, sclk=1, m_valid=0, m_data=0, overrun=0, busy=0, FSM=IDLE, accumulators=0.
- FSM: IDLE -> SETUP -> SHIFT -> QUIET -> (SETUP | IDLE).
- IDLE: cs_n=1, sclk=1. Leaves when enable && (continuous || start). On leaving, latch avg_log2 for the burst, clear accumulators and frame counter. start while busy ignored.
- SETUP: cs_n=0, sclk=1 for CLKS_CS_SETUP cycles.
- SHIFT: SAMPLE_BITS periods. Each period: sclk=0 for CLKS_PER_BIT/2 cycles, then sclk=1 for CLKS_PER_BIT/2. All sdin bits sampled on the clk edge where sclk goes 0->1, shifted in MSB first. cs_n=0 throughout. Total cs_n low = CLKS_CS_SETUP + SAMPLE_BITS*CLKS_PER_BIT cycles.
- End of SHIFT: cs_n=1, sclk=1. Each channel's low DATA_BITS are added to its accumulator (width DATA_BITS+7, unsigned). Frame counter increments.
- If frame counter reaches 2^avg_log2: result_k = acc_k >> avg_log2 (truncating) is loaded into m_data, and m_valid=1 on the first QUIET cycle. Accumulators and counter are then cleared.
- QUIET: CLKS_QUIET cycles with cs_n=1. Then:
  - SETUP if enable && (continuous || average incomplete);
  - otherwise IDLE.
- Single-shot: exactly one result per start (2^avg_log2 frames).
- enable deasserted mid-burst: current frame completes, partial average is discarded (no m_valid), QUIET runs, then IDLE. No frame is ever truncated while cs_n is low.
- Output handshake:
  - Transfer when m_valid && m_ready; m_valid drops the next cycle unless a new result loads in the same cycle.
  - New result while m_valid && !m_ready: m_data overwritten with the newer result, m_valid stays 1, overrun set.
  - New result in the same cycle as a transfer: no overrun, new data loaded, m_valid stays 1.
  - m_data holds its value after transfer.
- overrun cleared only by clear_ovr or reset. clear_ovr coincident with a new overrun event: overrun stays 1 (set wins).
- Changing continuous or avg_log2 mid-burst has no effect until the next IDLE exit. continuous falling mid-burst: the current average finishes, then IDLE.

Test Plan:
- Bench config NUM_CH=2, DATA_BITS=12, SAMPLE_BITS=16, CLKS_PER_BIT=4, CLKS_CS_SETUP=2, CLKS_QUIET=4, avg_log2=0, single-shot start. ADC model drives 0x0ABC (ch0) and 0x0123 (ch1) -> cs_n low exactly 66 cycles, 16 sclk rising edges, m_valid once, m_data=24'h123ABC, busy falls after QUIET.
- avg_log2=2, ch0 frames 100,101,102,103, ch1 constant 4095 -> exactly one m_valid after the 4th frame, ch0=101, ch1=4095.
- continuous=1, m_ready=0, ch0 values 5 then 6 -> after the 2nd result m_valid=1, ch0=6, overrun=1. clear_ovr pulse -> overrun=0.
- continuous=1, m_ready held 1 -> one transfer per frame (frame period 70 cycles), overrun stays 0; m_ready pulsed on the result-load cycle gives no overrun.
- enable dropped mid-SHIFT with avg_log2=1 on the first frame -> frame completes (66 cycles cs_n low), no m_valid, IDLE after QUIET. start during busy has no effect.
- reset_n asserted mid-SHIFT -> same cycle cs_n=1, sclk=1, m_valid=0, overrun=0. After release, a new start yields correct data.
